// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: walks a square N x N matrix multiply as a sequence of
// TILE x TILE engine jobs, row-major over (a_loc, b_loc), with a host-facing
// start/done/error handshake. All outputs are registered.
//
// Ports:
//   clk, resetn          rising-edge clock, synchronous active-low reset
//   start_reg            host request to run one full multiply (accepted in IDLE only)
//   clear_done_reg       host acknowledge of done/error (honoured in DONE/ERR only)
//   mat_size[7:0]        matrix edge N, sampled when a job starts
//   done_mat_mul         engine reports current tile complete (honoured in WAIT only)
//   start_mat_mul        engine start level, high until the engine reports done
//   a_loc, b_loc [7:0]   row / column offset of the current tile
//   final_mat_mul_size   N latched at job start
//   tile_count[7:0]      tiles completed in the current job
//   busy, done_reg, error  job status; done_reg and error are sticky
//
// Optional build macro TILE_SEQ_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC
// cycles; without it WAIT waits indefinitely for the engine.

module matmul_tile_sequencer #(
  parameter int TILE        = 4,
  parameter int MAX_SIZE    = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start_reg,
  input  logic       clear_done_reg,
  input  logic [7:0] mat_size,
  input  logic       done_mat_mul,
  output logic       start_mat_mul,
  output logic [7:0] a_loc,
  output logic [7:0] b_loc,
  output logic [7:0] final_mat_mul_size,
  output logic [7:0] tile_count,
  output logic       busy,
  output logic       done_reg,
  output logic       error
);

  // Parameter sanity: offsets and sizes are carried on 8-bit buses.
  generate
    if (TILE < 1 || TILE > 255 || MAX_SIZE < TILE || MAX_SIZE > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("matmul_tile_sequencer: unsupported parameter combination");
    end
  endgenerate

  localparam logic [7:0] TILE_W = 8'(TILE);
  localparam logic [7:0] MAX_W  = 8'(MAX_SIZE);
  localparam logic [8:0] TILE_9 = 9'(TILE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic       start_mat_mul_q, start_mat_mul_d;
  logic [7:0] a_loc_q, a_loc_d;
  logic [7:0] b_loc_q, b_loc_d;
  logic [7:0] final_size_q, final_size_d;
  logic [7:0] tile_count_q, tile_count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

`ifdef TILE_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Job request check on the live mat_size; only used in IDLE.
  logic size_ok;
  assign size_ok = (mat_size != 8'd0) &&
                   ((mat_size % TILE_W) == 8'd0) &&
                   (mat_size <= MAX_W);

  // Last tile is the bottom-right corner of the latched matrix.
  logic [7:0] last_off;
  logic       last_tile;
  assign last_off  = final_size_q - TILE_W;
  assign last_tile = (a_loc_q == last_off) && (b_loc_q == last_off);

  // Next column offset, computed one bit wider so the wrap compare is exact
  // even when N sits close to 255.
  logic [8:0] b_next;
  logic       b_wrap;
  assign b_next = {1'b0, b_loc_q} + TILE_9;
  assign b_wrap = (b_next >= {1'b0, final_size_q});

  always_comb begin
    state_d         = state_q;
    start_mat_mul_d = start_mat_mul_q;
    a_loc_d         = a_loc_q;
    b_loc_d         = b_loc_q;
    final_size_d    = final_size_q;
    tile_count_d    = tile_count_q;
    busy_d          = busy_q;
    done_d          = done_q;
    error_d         = error_q;
`ifdef TILE_SEQ_TIMEOUT_EN
    wait_cnt_d      = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_reg) begin
          if (size_ok) begin
            final_size_d    = mat_size;
            a_loc_d         = 8'd0;
            b_loc_d         = 8'd0;
            tile_count_d    = 8'd0;
            start_mat_mul_d = 1'b1;
            busy_d          = 1'b1;
            state_d         = S_WAIT;
`ifdef TILE_SEQ_TIMEOUT_EN
            wait_cnt_d      = '0;
`endif
          end else begin
            error_d = 1'b1;
            state_d = S_ERR;
          end
        end
      end

      S_WAIT: begin
        if (done_mat_mul) begin
          start_mat_mul_d = 1'b0;
          tile_count_d    = tile_count_q + 8'd1;
          if (last_tile) begin
            // Offsets stay on the final tile so the host can read them back.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            if (b_wrap) begin
              b_loc_d = 8'd0;
              a_loc_d = a_loc_q + TILE_W;
            end else begin
              b_loc_d = b_next[7:0];
            end
            state_d = S_GAP;
          end
        end
`ifdef TILE_SEQ_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          // Engine has been silent for TIMEOUT_CYC cycles: abandon the job.
          start_mat_mul_d = 1'b0;
          busy_d          = 1'b0;
          error_d         = 1'b1;
          state_d         = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      // Single cycle with start low so the engine sees a fresh rising edge.
      S_GAP: begin
        start_mat_mul_d = 1'b1;
        state_d         = S_WAIT;
`ifdef TILE_SEQ_TIMEOUT_EN
        wait_cnt_d      = '0;
`endif
      end

      S_DONE, S_ERR: begin
        if (clear_done_reg) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d         = S_IDLE;
        start_mat_mul_d = 1'b0;
        busy_d          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      start_mat_mul_q <= 1'b0;
      a_loc_q         <= 8'd0;
      b_loc_q         <= 8'd0;
      final_size_q    <= 8'd0;
      tile_count_q    <= 8'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
`ifdef TILE_SEQ_TIMEOUT_EN
      wait_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      start_mat_mul_q <= start_mat_mul_d;
      a_loc_q         <= a_loc_d;
      b_loc_q         <= b_loc_d;
      final_size_q    <= final_size_d;
      tile_count_q    <= tile_count_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
`ifdef TILE_SEQ_TIMEOUT_EN
      wait_cnt_q      <= wait_cnt_d;
`endif
    end
  end

  assign start_mat_mul      = start_mat_mul_q;
  assign a_loc              = a_loc_q;
  assign b_loc              = b_loc_q;
  assign final_mat_mul_size = final_size_q;
  assign tile_count         = tile_count_q;
  assign busy               = busy_q;
  assign done_reg           = done_q;
  assign error              = error_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer (TILE=4, MAX_SIZE=16, TIMEOUT_CYC=255).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Summary line reports total checks and errors.

module tb_matmul_tile_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_reg;
  logic       clear_done_reg;
  logic [7:0] mat_size;
  logic       done_mat_mul;
  logic       start_mat_mul;
  logic [7:0] a_loc;
  logic [7:0] b_loc;
  logic [7:0] final_mat_mul_size;
  logic [7:0] tile_count;
  logic       busy;
  logic       done_reg;
  logic       error;

  int checks = 0;
  int errors = 0;

  matmul_tile_sequencer #(.TILE(4), .MAX_SIZE(16), .TIMEOUT_CYC(255)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start_reg          (start_reg),
    .clear_done_reg     (clear_done_reg),
    .mat_size           (mat_size),
    .done_mat_mul       (done_mat_mul),
    .start_mat_mul      (start_mat_mul),
    .a_loc              (a_loc),
    .b_loc              (b_loc),
    .final_mat_mul_size (final_mat_mul_size),
    .tile_count         (tile_count),
    .busy               (busy),
    .done_reg           (done_reg),
    .error              (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start_reg = 1'b0; clear_done_reg = 1'b0;
    mat_size = 8'd0; done_mat_mul = 1'b0;
    tick(); tick();
    checks++;
    if ({start_mat_mul, busy, done_reg, error} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {start_mat_mul, busy, done_reg, error});
    end
    checks++;
    if ({a_loc, b_loc, final_mat_mul_size, tile_count} !== 32'h0) begin
      errors++; $display("FAIL reset_buses: got %h expected 00000000", {a_loc, b_loc, final_mat_mul_size, tile_count});
    end
    resetn = 1'b1;
    tick();
  endtask

  // N=4: one tile, engine done after 10 WAIT cycles.
  task automatic test_single_tile();
    int rises;
    logic prev;
    rises = 0;
    prev  = start_mat_mul;
    mat_size = 8'd4; start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    checks++;
    if ({start_mat_mul, busy, final_mat_mul_size, a_loc, b_loc, tile_count} !== {2'b11, 8'd4, 8'd0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL n4_start: got st=%b busy=%b N=%0d a=%0d b=%0d tc=%0d expected st=1 busy=1 N=4 a=0 b=0 tc=0",
                         start_mat_mul, busy, final_mat_mul_size, a_loc, b_loc, tile_count);
    end
    for (int i = 0; i < 10; i++) begin
      if (start_mat_mul && !prev) rises++;
      prev = start_mat_mul;
      tick();
    end
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (start_mat_mul && !prev) rises++;
      prev = start_mat_mul;
      tick();
    end
    checks++;
    if (rises !== 1) begin
      errors++; $display("FAIL n4_windows: got %0d start windows expected 1", rises);
    end
    checks++;
    if ({start_mat_mul, busy, done_reg, error, a_loc, b_loc, tile_count} !== {4'b0010, 8'd0, 8'd0, 8'd1}) begin
      errors++; $display("FAIL n4_done: got st=%b busy=%b done=%b err=%b a=%0d b=%0d tc=%0d expected 0 0 1 0 a=0 b=0 tc=1",
                         start_mat_mul, busy, done_reg, error, a_loc, b_loc, tile_count);
    end
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
    checks++;
    if ({done_reg, busy, start_mat_mul} !== 3'b000) begin
      errors++; $display("FAIL n4_clear: got %b expected 000", {done_reg, busy, start_mat_mul});
    end
  endtask

  // N=8: four tiles in row-major order, one-cycle gap, mid-job size change and
  // a stale done pulse during the gap.
  task automatic test_n8_sequence();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a[0] = 8'd0; exp_b[0] = 8'd0;
    exp_a[1] = 8'd0; exp_b[1] = 8'd4;
    exp_a[2] = 8'd4; exp_b[2] = 8'd0;
    exp_a[3] = 8'd4; exp_b[3] = 8'd4;
    mat_size = 8'd8; start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    mat_size  = 8'd4;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if ({start_mat_mul, a_loc, b_loc, final_mat_mul_size} !== {1'b1, exp_a[t], exp_b[t], 8'd8}) begin
        errors++; $display("FAIL n8_tile%0d: got st=%b a=%0d b=%0d N=%0d expected st=1 a=%0d b=%0d N=8",
                           t, start_mat_mul, a_loc, b_loc, final_mat_mul_size, exp_a[t], exp_b[t]);
      end
      tick(); tick();
      done_mat_mul = 1'b1;
      tick();
      checks++;
      if ({start_mat_mul, tile_count} !== {1'b0, 8'(t + 1)}) begin
        errors++; $display("FAIL n8_after%0d: got st=%b tc=%0d expected st=0 tc=%0d", t, start_mat_mul, tile_count, t + 1);
      end
      if (t == 0) begin
        // done still high during GAP: must be ignored
        tick();
        done_mat_mul = 1'b0;
        checks++;
        if ({start_mat_mul, tile_count} !== {1'b1, 8'd1}) begin
          errors++; $display("FAIL n8_gap_done: got st=%b tc=%0d expected st=1 tc=1", start_mat_mul, tile_count);
        end
      end else if (t < 3) begin
        done_mat_mul = 1'b0;
        tick();
      end
    end
    done_mat_mul = 1'b0;
    checks++;
    if ({busy, done_reg, tile_count, a_loc, b_loc} !== {2'b01, 8'd4, 8'd4, 8'd4}) begin
      errors++; $display("FAIL n8_done: got busy=%b done=%b tc=%0d a=%0d b=%0d expected 0 1 4 4 4",
                         busy, done_reg, tile_count, a_loc, b_loc);
    end
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
  endtask

  task automatic test_invalid_sizes();
    logic [7:0] bad [3];
    bad[0] = 8'd6; bad[1] = 8'd0; bad[2] = 8'd20;
    for (int k = 0; k < 3; k++) begin
      int st_seen;
      st_seen = 0;
      mat_size = bad[k]; start_reg = 1'b1;
      tick();
      start_reg = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (start_mat_mul) st_seen++;
        tick();
      end
      checks++;
      if ({error, busy, done_reg, st_seen[0]} !== 4'b1000 || st_seen != 0) begin
        errors++; $display("FAIL invalid_N%0d: got err=%b busy=%b done=%b start_seen=%0d expected err=1 busy=0 done=0 start_seen=0",
                           bad[k], error, busy, done_reg, st_seen);
      end
      clear_done_reg = 1'b1;
      tick();
      clear_done_reg = 1'b0;
      checks++;
      if ({error, start_mat_mul} !== 2'b00) begin
        errors++; $display("FAIL invalid_clear_N%0d: got err=%b st=%b expected 0 0", bad[k], error, start_mat_mul);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    mat_size = 8'd16; start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      done_mat_mul = 1'b1;
      tick();
      done_mat_mul = 1'b0;
      tick();
    end
    checks++;
    if ({start_mat_mul, busy, a_loc, b_loc, tile_count} !== {2'b11, 8'd4, 8'd0, 8'd4}) begin
      errors++; $display("FAIL n16_tile5: got st=%b busy=%b a=%0d b=%0d tc=%0d expected 1 1 a=4 b=0 tc=4",
                         start_mat_mul, busy, a_loc, b_loc, tile_count);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if ({start_mat_mul, busy, done_reg, error, a_loc, b_loc, final_mat_mul_size, tile_count} !== 36'h0) begin
      errors++; $display("FAIL midjob_reset: got %h expected 000000000",
                         {start_mat_mul, busy, done_reg, error, a_loc, b_loc, final_mat_mul_size, tile_count});
    end
    resetn = 1'b1;
    mat_size = 8'd4; start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    tick();
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    checks++;
    if ({done_reg, busy, tile_count, final_mat_mul_size} !== {2'b10, 8'd1, 8'd4}) begin
      errors++; $display("FAIL post_reset_job: got done=%b busy=%b tc=%0d N=%0d expected 1 0 1 4",
                         done_reg, busy, tile_count, final_mat_mul_size);
    end
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
  endtask

  task automatic test_timeout();
    mat_size = 8'd4; start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
`ifdef TILE_SEQ_TIMEOUT_EN
    begin
      int high;
      high = 0;
      while (start_mat_mul && high < 400) begin
        high++;
        tick();
      end
      checks++;
      if (high !== 255) begin
        errors++; $display("FAIL timeout_len: got %0d WAIT cycles expected 255", high);
      end
      checks++;
      if ({error, start_mat_mul, busy} !== 3'b100) begin
        errors++; $display("FAIL timeout_flags: got err=%b st=%b busy=%b expected 1 0 0", error, start_mat_mul, busy);
      end
      clear_done_reg = 1'b1;
      tick();
      clear_done_reg = 1'b0;
    end
`else
    repeat (1000) tick();
    checks++;
    if ({start_mat_mul, busy, error} !== 3'b110) begin
      errors++; $display("FAIL no_timeout: got st=%b busy=%b err=%b expected 1 1 0", start_mat_mul, busy, error);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
`endif
  endtask

  // start_reg held through DONE and clear; done pulse in DONE ignored.
  task automatic test_back_to_back();
    mat_size = 8'd4; start_reg = 1'b1;
    tick();
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    tick(); tick();
    checks++;
    if ({done_reg, start_mat_mul, busy, tile_count} !== {3'b100, 8'd1}) begin
      errors++; $display("FAIL held_start_done: got done=%b st=%b busy=%b tc=%0d expected 1 0 0 1",
                         done_reg, start_mat_mul, busy, tile_count);
    end
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    tick();
    checks++;
    if ({done_reg, tile_count} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL done_pulse_in_done: got done=%b tc=%0d expected 1 1", done_reg, tile_count);
    end
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
    checks++;
    if ({done_reg, start_mat_mul, busy} !== 3'b000) begin
      errors++; $display("FAIL clear_to_idle: got %b expected 000", {done_reg, start_mat_mul, busy});
    end
    tick();
    start_reg = 1'b0;
    checks++;
    if ({start_mat_mul, busy, tile_count} !== {2'b11, 8'd0}) begin
      errors++; $display("FAIL restart_from_idle: got st=%b busy=%b tc=%0d expected 1 1 0", start_mat_mul, busy, tile_count);
    end
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_n8_sequence();
    test_invalid_sizes();
    test_reset_mid_job();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sequencer.md
MATMUL_TILE_SEQUENCER -- requirements
Module: matmul_tile_sequencer

Interface
REQ-001 Parameter TILE, default 4: edge length of one engine tile, in elements.
REQ-002 Parameter MAX_SIZE, default 16: largest supported matrix edge, in elements.
REQ-003 Parameter TIMEOUT_CYC, default 255: watchdog limit in cycles. Used only when TILE_SEQ_TIMEOUT_EN is defined.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 start_reg  input  1  host request to run one full matrix multiply.
REQ-007 clear_done_reg  input  1  host acknowledge; clears done or error.
REQ-008 mat_size  input  8  matrix edge N in elements; sampled at job start.
REQ-009 done_mat_mul  input  1  engine reports that the current tile is complete.
REQ-010 start_mat_mul  output  1  engine start level; held high until the engine reports done.
REQ-011 a_loc  output  8  row offset of the current tile, in elements.
REQ-012 b_loc  output  8  column offset of the current tile, in elements.
REQ-013 final_mat_mul_size  output  8  latched N, forwarded to the engine.
REQ-014 tile_count  output  8  number of tiles completed in the current job.
REQ-015 busy  output  1  high while a job is in progress.
REQ-016 done_reg  output  1  job complete, sticky.
REQ-017 error  output  1  invalid size or timeout, sticky.

Function
REQ-018 States: IDLE, WAIT, GAP, DONE, ERR. All outputs shall be registered.
REQ-019 IDLE with start_reg=1 and N valid (N nonzero, N mod TILE = 0, N <= MAX_SIZE):
  - latch N into final_mat_mul_size;
  - set a_loc=0, b_loc=0, tile_count=0;
  - set start_mat_mul=1, busy=1;
  - go to WAIT.
REQ-020 IDLE with start_reg=1 and N invalid: set error=1 and go to ERR; start_mat_mul stays 0.
REQ-021 WAIT with done_mat_mul=1:
  - clear start_mat_mul;
  - increment tile_count;
  - if the tile was the last one (a_loc=N-TILE and b_loc=N-TILE), set busy=0, done_reg=1 and go to DONE;
  - otherwise go to GAP.
REQ-022 Tile order: b_loc is the inner loop and a_loc the outer loop. On leaving a non-last tile:
  - b_loc += TILE;
  - when b_loc wraps to 0, a_loc += TILE.
REQ-023 GAP lasts exactly one cycle: set start_mat_mul=1 and return to WAIT. start_mat_mul shall therefore be low for exactly one cycle between tiles.
REQ-024 A job shall run (N/TILE)^2 tiles; tile_count shall equal that number on entry to DONE.
REQ-025 DONE and ERR shall hold until clear_done_reg=1. On that edge: clear done_reg and error, and go to IDLE.
REQ-026 start_reg shall be ignored outside IDLE, and clear_done_reg outside DONE/ERR. Neither shall ever queue.
REQ-027 Changes to mat_size during a job shall not affect the job.
REQ-028 A done_mat_mul pulse seen in IDLE, GAP, DONE or ERR shall be ignored.

Reset
REQ-029 resetn=0 at a clock edge shall force IDLE and clear all outputs to 0, including during an active job.
REQ-030 The first start_reg after reset release shall be accepted normally.

Configuration
REQ-031 Macro TILE_SEQ_TIMEOUT_EN defined:
  - a cycle counter clears on every entry to WAIT;
  - if WAIT lasts TIMEOUT_CYC cycles without done_mat_mul: clear start_mat_mul and busy, set error=1, go to ERR.
REQ-032 Macro TILE_SEQ_TIMEOUT_EN undefined: no counter exists, WAIT is unbounded, and error asserts only for an invalid N.

Verification
REQ-033 N=4, start pulse, engine done 10 cycles later -> exactly one start window; a_loc=b_loc=0; tile_count=1; done_reg=1; busy=0.
REQ-034 N=8 -> tile sequence (a_loc,b_loc) = (0,0),(0,4),(4,0),(4,4); one-cycle start_mat_mul low gap between tiles; tile_count=4 at done.
REQ-035 N=6, then N=0, then N=20 -> each gives error=1 with start_mat_mul never high; clear_done_reg returns to IDLE.
REQ-036 N=16, resetn=0 during tile 5 -> all outputs 0 next cycle; a new N=4 job completes normally.
REQ-037 With TILE_SEQ_TIMEOUT_EN, engine never reports done -> error=1 after 255 WAIT cycles and start_mat_mul=0. Without the macro, start_mat_mul stays high after 1000 cycles.
REQ-038 start_reg held high through a DONE-then-clear sequence -> new job starts only after IDLE is re-entered; done_mat_mul pulsed while in DONE -> no effect.
